chained_hash_table: RTL and testbench

Parametrised successor to the team's chained hash table: a bucket array of head pointers, a flat entry pool and a freelist, with INSERT/LOOKUP/ERASE/CLEAR operations. It adds a valid/ready request and response handshake, self-initialisation after reset, selectable hashing, a probe limit and occupancy reporting. It sits between the order-book control logic and the order-ID → record-pointer map, one request in flight at a time.

---
 rtl/hash_table_pkg.sv | 22 ++
 rtl/hash_index_fold.sv | 29 ++
 rtl/chained_hash_table.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_chained_hash_table.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared encodings for the chained hash table: request opcodes, FSM states
// and the all-ones NULL pointer helper.
package hash_table_pkg;

  localparam logic [1:0] OP_CLEAR  = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_LOOKUP = 2'd2;
  localparam logic [1:0] OP_ERASE  = 2'd3;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_WALK  = 3'd2;
  localparam logic [2:0] ST_ALLOC = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // All-ones pattern of the given pointer width; callers cast to their width.
  function automatic logic [31:0] null_ptr(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/hash_index_fold.sv
// Bucket index from a key: either the key's low bits or an XOR-fold of all
// INDEX_WIDTH-bit slices (top slice zero-padded).
module hash_index_fold #(
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH = 13,
  parameter int unsigned HASH_MODE   = 0
) (
  input  logic [KEY_WIDTH-1:0]   key,
  output logic [INDEX_WIDTH-1:0] index_c
);

  localparam int unsigned N_SLICES  = (KEY_WIDTH + INDEX_WIDTH - 1) / INDEX_WIDTH;
  localparam int unsigned PAD_WIDTH = N_SLICES * INDEX_WIDTH;

  logic [PAD_WIDTH-1:0] key_pad;

  always_comb begin
    key_pad = PAD_WIDTH'(key);
    index_c = '0;
    if (HASH_MODE == 0) begin
      index_c = key_pad[INDEX_WIDTH-1:0];
    end else begin
      for (int unsigned i = 0; i < N_SLICES; i++) begin
        index_c = index_c ^ key_pad[i*INDEX_WIDTH +: INDEX_WIDTH];
      end
    end
  end

endmodule

// File: rtl/chained_hash_table.sv
// Chained hash table: bucket head array, flat entry pool with freelist,
// one request in flight, self-initialising after reset and on CLEAR.
module chained_hash_table
  import hash_table_pkg::*;
#(
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned VALUE_WIDTH = 64,
  parameter int unsigned TABLE_SIZE  = 8192,
  parameter int unsigned POOL_SIZE   = 131072,
  parameter int unsigned MAX_PROBE   = 64,
  parameter int unsigned HASH_MODE   = 0,
  parameter int unsigned INDEX_WIDTH = $clog2(TABLE_SIZE),
  parameter int unsigned PTR_WIDTH   = $clog2(POOL_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_success,
  output logic                   rsp_hit,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic [PTR_WIDTH-1:0]   count,
  output logic                   full,
  output logic                   busy
);

  localparam int unsigned POOL_AW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int unsigned INIT_N  = (TABLE_SIZE > POOL_SIZE) ? TABLE_SIZE : POOL_SIZE;
  localparam int unsigned INIT_W  = (INIT_N > 1) ? $clog2(INIT_N) : 1;
  localparam int unsigned PROBE_W = $clog2(MAX_PROBE + 1);
  localparam logic [PTR_WIDTH-1:0] NIL = PTR_WIDTH'(null_ptr(PTR_WIDTH));

  logic [PTR_WIDTH-1:0]   buckets  [TABLE_SIZE];
  logic [KEY_WIDTH-1:0]   key_mem  [POOL_SIZE];
  logic [VALUE_WIDTH-1:0] val_mem  [POOL_SIZE];
  logic [PTR_WIDTH-1:0]   next_mem [POOL_SIZE];

  logic [2:0]             state, state_n;
  logic [INIT_W-1:0]      init_cnt, init_n;
  logic                   clear_pend, clear_n;
  logic [1:0]             op_q, op_n;
  logic [KEY_WIDTH-1:0]   key_q, key_n;
  logic [VALUE_WIDTH-1:0] value_q, value_n;
  logic [INDEX_WIDTH-1:0] bkt_q, bkt_n;
  logic [PTR_WIDTH-1:0]   curr, curr_n, prev, prev_n, fl_head, fl_n;
  logic [PROBE_W-1:0]     probe, probe_n;
  logic [PTR_WIDTH-1:0]   count_n;
  logic                   succ_n, hit_n;
  logic [VALUE_WIDTH-1:0] rval_n;

  logic [INDEX_WIDTH-1:0] hash_c, bkt_ra, bkt_wa;
  logic [PTR_WIDTH-1:0]   bkt_rd, bkt_wd, curr_next, fl_next, nxt_wd_a, nxt_wd_b;
  logic [POOL_AW-1:0]     curr_a, prev_a, fl_a, nxt_wa_a, nxt_wa_b, ent_wa;
  logic [KEY_WIDTH-1:0]   curr_key;
  logic [VALUE_WIDTH-1:0] curr_val;
  logic                   bkt_we, nxt_we_a, nxt_we_b, ent_we;

  hash_index_fold #(
    .KEY_WIDTH   (KEY_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .HASH_MODE   (HASH_MODE)
  ) u_hash (
    .key     (req_key),
    .index_c (hash_c)
  );

  // Asynchronous memory reads feeding the single-cycle-per-node walk
  assign curr_a    = POOL_AW'(curr);
  assign prev_a    = POOL_AW'(prev);
  assign fl_a      = POOL_AW'(fl_head);
  assign bkt_ra    = (state == ST_IDLE) ? hash_c : bkt_q;
  assign bkt_rd    = buckets[bkt_ra];
  assign curr_key  = key_mem[curr_a];
  assign curr_val  = val_mem[curr_a];
  assign curr_next = next_mem[curr_a];
  assign fl_next   = next_mem[fl_a];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    init_n   = init_cnt;
    clear_n  = clear_pend;
    op_n     = op_q;
    key_n    = key_q;
    value_n  = value_q;
    bkt_n    = bkt_q;
    curr_n   = curr;
    prev_n   = prev;
    probe_n  = probe;
    fl_n     = fl_head;
    count_n  = count;
    succ_n   = rsp_success;
    hit_n    = rsp_hit;
    rval_n   = rsp_value;
    bkt_we   = 1'b0;
    bkt_wa   = bkt_q;
    bkt_wd   = NIL;
    nxt_we_a = 1'b0;
    nxt_wa_a = curr_a;
    nxt_wd_a = NIL;
    nxt_we_b = 1'b0;
    nxt_wa_b = prev_a;
    nxt_wd_b = curr_next;
    ent_we   = 1'b0;
    ent_wa   = curr_a;
    case (state)
      ST_INIT: begin
        if (32'(init_cnt) < TABLE_SIZE) begin
          bkt_we = 1'b1;
          bkt_wa = INDEX_WIDTH'(init_cnt);
        end
        if (32'(init_cnt) < POOL_SIZE) begin
          nxt_we_a = 1'b1;
          nxt_wa_a = POOL_AW'(init_cnt);
          nxt_wd_a = (32'(init_cnt) == POOL_SIZE - 1) ? NIL
                                                       : PTR_WIDTH'(32'(init_cnt) + 32'd1);
        end
        if (32'(init_cnt) == INIT_N - 1) begin
          fl_n    = '0;
          count_n = '0;
          if (clear_pend) begin
            state_n = ST_RESP;
            clear_n = 1'b0;
            succ_n  = 1'b1;
            hit_n   = 1'b0;
            rval_n  = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          init_n = init_cnt + INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_n    = req_op;
          key_n   = req_key;
          value_n = req_value;
          bkt_n   = hash_c;
          curr_n  = bkt_rd;
          prev_n  = NIL;
          probe_n = '0;
          if (req_op == OP_CLEAR) begin
            state_n = ST_INIT;
            init_n  = '0;
            clear_n = 1'b1;
          end else begin
            state_n = ST_WALK;
          end
        end
      end
      ST_WALK: begin
        if (curr == NIL) begin
          if (op_q == OP_INSERT) begin
            state_n = ST_ALLOC;
          end else begin
            state_n = ST_RESP;
            succ_n  = 1'b0;
            hit_n   = 1'b0;
            rval_n  = '0;
          end
        end else if (curr_key == key_q) begin
          state_n = ST_RESP;
          succ_n  = 1'b1;
          hit_n   = 1'b1;
          rval_n  = curr_val;
          if (op_q == OP_INSERT) ent_we = 1'b1;
          if (op_q == OP_ERASE) begin
            if (prev == NIL) begin
              bkt_we = 1'b1;
              bkt_wd = curr_next;
            end else begin
              nxt_we_b = 1'b1;
            end
            nxt_we_a = 1'b1;
            nxt_wd_a = fl_head;
            fl_n     = curr;
            count_n  = count - PTR_WIDTH'(1);
          end
        end else if ((32'(probe) + 32'd1 == MAX_PROBE) && (curr_next != NIL)) begin
          // Chain continues past the probe budget: give up without changes
          state_n = ST_RESP;
          succ_n  = 1'b0;
          hit_n   = 1'b0;
          rval_n  = '0;
        end else begin
          prev_n  = curr;
          curr_n  = curr_next;
          probe_n = probe + PROBE_W'(1);
        end
      end
      ST_ALLOC: begin
        state_n = ST_RESP;
        hit_n   = 1'b0;
        rval_n  = '0;
        if (fl_head == NIL) begin
          succ_n = 1'b0;
        end else begin
          succ_n   = 1'b1;
          ent_we   = 1'b1;
          ent_wa   = fl_a;
          nxt_we_a = 1'b1;
          nxt_wa_a = fl_a;
          nxt_wd_a = bkt_rd;
          bkt_we   = 1'b1;
          bkt_wd   = fl_head;
          fl_n     = fl_next;
          count_n  = count + PTR_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt    <= '0;
      clear_pend  <= 1'b0;
      op_q        <= OP_CLEAR;
      key_q       <= '0;
      value_q     <= '0;
      bkt_q       <= '0;
      curr        <= NIL;
      prev        <= NIL;
      probe       <= '0;
      fl_head     <= NIL;
      count       <= '0;
      full        <= 1'b0;
      busy        <= 1'b1;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_success <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_value   <= '0;
    end else begin
      init_cnt    <= init_n;
      clear_pend  <= clear_n;
      op_q        <= op_n;
      key_q       <= key_n;
      value_q     <= value_n;
      bkt_q       <= bkt_n;
      curr        <= curr_n;
      prev        <= prev_n;
      probe       <= probe_n;
      fl_head     <= fl_n;
      count       <= count_n;
      full        <= (32'(count_n) == POOL_SIZE);
      busy        <= (state_n == ST_INIT);
      req_ready   <= (state_n == ST_IDLE);
      rsp_valid   <= (state_n == ST_RESP);
      rsp_success <= succ_n;
      rsp_hit     <= hit_n;
      rsp_value   <= rval_n;
    end
  end

  // Table storage; contents are rebuilt by INIT so no reset is needed
  always_ff @(posedge clk) begin
    if (bkt_we) buckets[bkt_wa] <= bkt_wd;
    if (nxt_we_a) next_mem[nxt_wa_a] <= nxt_wd_a;
    if (nxt_we_b) next_mem[nxt_wa_b] <= nxt_wd_b;
    if (ent_we) begin
      key_mem[ent_wa] <= key_q;
      val_mem[ent_wa] <= value_q;
    end
  end

endmodule

// File: tb/tb_chained_hash_table.sv
// Directed bench for chained_hash_table: instance 0 hashes by low bits,
// instance 1 by XOR-fold; both use a 4-bucket, 4-entry, probe-3 table.
module tb_chained_hash_table;

  localparam logic [1:0] CLR = 2'd0, INS = 2'd1, LKP = 2'd2, ERS = 2'd3;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]       rsp_success, rsp_hit, full, busy;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_key;
  logic [1:0][15:0] req_value, rsp_value;
  logic [1:0][2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic        s, h;
  logic [15:0] v;
  int          e;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    chained_hash_table #(
      .KEY_WIDTH(32), .VALUE_WIDTH(16), .TABLE_SIZE(4), .POOL_SIZE(4),
      .MAX_PROBE(3), .HASH_MODE(g)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_op(req_op[g]),
      .req_key(req_key[g]), .req_value(req_value[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_success(rsp_success[g]), .rsp_hit(rsp_hit[g]), .rsp_value(rsp_value[g]),
      .count(count[g]), .full(full[g]), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request; edges counts clock edges from the accept edge (inclusive)
  // to the edge after which rsp_valid is seen.
  task automatic do_req(input int d, input logic [1:0] op, input logic [31:0] key,
                        input logic [15:0] val, input bit ack,
                        output logic succ, output logic hit, output logic [15:0] rval,
                        output int edges);
    int guard = 0;
    while (req_ready[d] !== 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL req_ready_timeout: dut %0d never ready", d);
    end
    req_valid[d] = 1'b1; req_op[d] = op; req_key[d] = key; req_value[d] = val;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    edges = 1;
    while (rsp_valid[d] !== 1'b1 && edges < 200) begin @(posedge clk); #1; edges++; end
    if (edges >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: dut %0d op %0d key %0h no response", d, op, key);
    end
    succ = rsp_success[d]; hit = rsp_hit[d]; rval = rsp_value[d];
    if (ack) begin
      rsp_ready[d] = 1'b1; @(posedge clk); #1; rsp_ready[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b0; req_valid = '0; rsp_ready = '0; req_op = '0; req_key = '0; req_value = '0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %0b expected 1", busy[0]); end
    n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %0b expected 0", req_ready[0]); end
    n_checks++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %0b expected 0", rsp_valid[0]); end
    n_checks++; if (count[0] !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count[0]); end
    n_checks++; if (full[0] !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0b expected 0", full[0]); end
    n_checks++; if ({rsp_success[0], rsp_hit[0], rsp_value[0]} !== 18'd0) begin n_fail++; $display("FAIL rst_rsp_fields: got %0h expected 0", {rsp_success[0], rsp_hit[0], rsp_value[0]}); end
    rst = 1'b1;
    while (busy[0] === 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL init_cycles: got %0d expected 4", n); end
    n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0b expected 1", req_ready[0]); end
  endtask

  task automatic test_insert_lookup();
    do_req(0, INS, 32'd5, 16'h00AA, 1'b1, s, h, v, e);
    n_checks++; if ({s, h} !== 2'b10) begin n_fail++; $display("FAIL ins5_succ_hit: got %b expected 10", {s, h}); end
    n_checks++; if (e != 3) begin n_fail++; $display("FAIL ins5_latency: got %0d expected 3", e); end
    n_checks++; if (count[0] !== 3'd1) begin n_fail++; $display("FAIL ins5_count: got %0d expected 1", count[0]); end
    do_req(0, LKP, 32'd5, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b11, 16'h00AA}) begin n_fail++; $display("FAIL lkp5: got %b/%h expected 11/00aa", {s, h}, v); end
    n_checks++; if (e != 2) begin n_fail++; $display("FAIL lkp5_latency: got %0d expected 2", e); end
  endtask

  task automatic test_overwrite();
    do_req(0, INS, 32'd5, 16'h00BB, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b11, 16'h00AA}) begin n_fail++; $display("FAIL ovw5_old: got %b/%h expected 11/00aa", {s, h}, v); end
    do_req(0, LKP, 32'd5, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if (v !== 16'h00BB) begin n_fail++; $display("FAIL ovw5_new: got %h expected 00bb", v); end
    n_checks++; if (count[0] !== 3'd1) begin n_fail++; $display("FAIL ovw5_count: got %0d expected 1", count[0]); end
  endtask

  task automatic test_fill_and_limits();
    do_req(0, INS, 32'd1, 16'h0011, 1'b1, s, h, v, e);
    n_checks++; if (e != 4) begin n_fail++; $display("FAIL ins1_chain_latency: got %0d expected 4", e); end
    do_req(0, INS, 32'd9, 16'h0099, 1'b1, s, h, v, e);
    do_req(0, INS, 32'd13, 16'h0013, 1'b1, s, h, v, e);
    n_checks++; if ({s, h} !== 2'b10) begin n_fail++; $display("FAIL ins13_succ_hit: got %b expected 10", {s, h}); end
    n_checks++; if ({full[0], count[0]} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL fill_full_count: got %0b/%0d expected 1/4", full[0], count[0]); end
    do_req(0, INS, 32'd2, 16'h0022, 1'b1, s, h, v, e);
    n_checks++; if ({s, h} !== 2'b00) begin n_fail++; $display("FAIL ins2_pool_full: got %b expected 00", {s, h}); end
    do_req(0, LKP, 32'd1, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b11, 16'h0011} || e != 4) begin n_fail++; $display("FAIL lkp1_node2: got %b/%h lat %0d expected 11/0011 lat 4", {s, h}, v, e); end
    do_req(0, LKP, 32'd5, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b00, 16'h0}) begin n_fail++; $display("FAIL lkp5_probe_limit: got %b/%h expected 00/0000", {s, h}, v); end
  endtask

  task automatic test_erase();
    do_req(0, ERS, 32'd9, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b11, 16'h0099}) begin n_fail++; $display("FAIL ers9: got %b/%h expected 11/0099", {s, h}, v); end
    n_checks++; if ({full[0], count[0]} !== {1'b0, 3'd3}) begin n_fail++; $display("FAIL ers9_count: got %0b/%0d expected 0/3", full[0], count[0]); end
    do_req(0, LKP, 32'd9, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h} !== 2'b00) begin n_fail++; $display("FAIL lkp9_miss: got %b expected 00", {s, h}); end
    do_req(0, LKP, 32'd5, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b11, 16'h00BB}) begin n_fail++; $display("FAIL lkp5_after_unlink: got %b/%h expected 11/00bb", {s, h}, v); end
    do_req(0, INS, 32'd2, 16'h0022, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, count[0]} !== {2'b10, 3'd4}) begin n_fail++; $display("FAIL ins2_reuse: got %b/%0d expected 10/4", {s, h}, count[0]); end
  endtask

  task automatic test_back_pressure();
    do_req(0, LKP, 32'd2, 16'h0, 1'b0, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b11, 16'h0022}) begin n_fail++; $display("FAIL lkp2: got %b/%h expected 11/0022", {s, h}, v); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({rsp_valid[0], rsp_success[0], rsp_hit[0], rsp_value[0], req_ready[0]} !== {3'b111, 16'h0022, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v%0b s%0b h%0b val %h rdy %0b expected v1 s1 h1 val 0022 rdy 0",
                 i, rsp_valid[0], rsp_success[0], rsp_hit[0], rsp_value[0], req_ready[0]);
      end
    end
    rsp_ready[0] = 1'b1; @(posedge clk); #1; rsp_ready[0] = 1'b0;
    n_checks++; if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin n_fail++; $display("FAIL after_handshake: got %b expected 01", {rsp_valid[0], req_ready[0]}); end
  endtask

  task automatic test_reset_mid_walk();
    int   n = 0;
    logic seen = 1'b0;
    req_valid[0] = 1'b1; req_op[0] = LKP; req_key[0] = 32'd5;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b0; #1;
    n_checks++; if ({rsp_valid[0], busy[0], req_ready[0], count[0]} !== {3'b010, 3'd0}) begin n_fail++; $display("FAIL abort_state: got %b/%0d expected 010/0", {rsp_valid[0], busy[0], req_ready[0]}, count[0]); end
    @(posedge clk); #1;
    rst = 1'b1;
    while (busy[0] === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      if (rsp_valid[0] === 1'b1) seen = 1'b1;
      n++;
    end
    n_checks++; if (seen !== 1'b0 || n != 4) begin n_fail++; $display("FAIL abort_reinit: got rsp %0b init %0d expected 0/4", seen, n); end
    do_req(0, LKP, 32'd5, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, count[0]} !== {2'b00, 3'd0}) begin n_fail++; $display("FAIL lkp5_after_reset: got %b/%0d expected 00/0", {s, h}, count[0]); end
  endtask

  task automatic test_clear();
    do_req(0, INS, 32'd6, 16'h0066, 1'b1, s, h, v, e);
    n_checks++; if (count[0] !== 3'd1) begin n_fail++; $display("FAIL pre_clear_count: got %0d expected 1", count[0]); end
    do_req(0, CLR, 32'd0, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h, v} !== {2'b10, 16'h0} || e != 5) begin n_fail++; $display("FAIL clear_rsp: got %b/%h lat %0d expected 10/0000 lat 5", {s, h}, v, e); end
    n_checks++; if (count[0] !== 3'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", count[0]); end
    do_req(0, LKP, 32'd6, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if ({s, h} !== 2'b00) begin n_fail++; $display("FAIL lkp6_after_clear: got %b expected 00", {s, h}); end
  endtask

  task automatic test_hash_mode();
    // Low-bits hash: keys 1 and 4 use buckets 1 and 0
    do_req(0, INS, 32'd1, 16'h0101, 1'b1, s, h, v, e);
    do_req(0, INS, 32'd4, 16'h0404, 1'b1, s, h, v, e);
    n_checks++; if (e != 3) begin n_fail++; $display("FAIL m0_ins4_latency: got %0d expected 3", e); end
    do_req(0, LKP, 32'd1, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if (e != 2 || v !== 16'h0101) begin n_fail++; $display("FAIL m0_lkp1: got lat %0d val %h expected 2/0101", e, v); end
    // XOR-fold: key 4 folds to bucket 1, chaining ahead of key 1
    do_req(1, INS, 32'd1, 16'h0101, 1'b1, s, h, v, e);
    n_checks++; if (e != 3) begin n_fail++; $display("FAIL m1_ins1_latency: got %0d expected 3", e); end
    do_req(1, INS, 32'd4, 16'h0404, 1'b1, s, h, v, e);
    n_checks++; if (e != 4) begin n_fail++; $display("FAIL m1_ins4_latency: got %0d expected 4", e); end
    do_req(1, LKP, 32'd1, 16'h0, 1'b1, s, h, v, e);
    n_checks++; if (e != 3 || v !== 16'h0101) begin n_fail++; $display("FAIL m1_lkp1: got lat %0d val %h expected 3/0101", e, v); end
    n_checks++; if (count[1] !== 3'd2) begin n_fail++; $display("FAIL m1_count: got %0d expected 2", count[1]); end
  endtask

  initial begin
    test_reset();
    test_insert_lookup();
    test_overwrite();
    test_fill_and_limits();
    test_erase();
    test_back_pressure();
    test_reset_mid_walk();
    test_clear();
    test_hash_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
